// File: rtl/eb_skp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eb_skp_ctrl: elastic-buffer read sequencer with SKP add/delete        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module eb_skp_ctrl #(
  parameter int         ADDR_WIDTH    = 4,
  parameter int         ADD_THRESHOLD = 6,
  parameter int         DEL_THRESHOLD = 10,
  parameter logic [9:0] SKP_SYM1      = 10'h0f9,
  parameter logic [9:0] SKP_SYM2      = 10'h306,
  parameter int         CNT_WIDTH     = 8
) (
  input  logic                  lclk,
  input  logic                  lrst,
  input  logic                  en,
  input  logic [ADDR_WIDTH:0]   occupancy,
  input  logic [9:0]            in_data,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [9:0]            out_data,
  output logic                  out_vld,
  output logic                  skp_added,
  output logic                  skp_deleted,
  output logic [CNT_WIDTH-1:0]  add_cnt,
  output logic [CNT_WIDTH-1:0]  del_cnt
);

  localparam logic [ADDR_WIDTH:0] c_add_thr = ADD_THRESHOLD[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] c_del_thr = DEL_THRESHOLD[ADDR_WIDTH:0];

  typedef enum logic [1:0] {
    S_PASS  = 2'd0,
    S_INS_A = 2'd1,
    S_INS_B = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_add_req;
  logic                 r_del_req;
  logic [9:0]           r_h_data;
  logic                 r_h_vld;
  logic [9:0]           r_out_data;
  logic                 r_out_vld;
  logic                 r_skp_added;
  logic                 r_skp_deleted;
  logic [CNT_WIDTH-1:0] r_add_cnt;
  logic [CNT_WIDTH-1:0] r_del_cnt;

  logic                 w_pop;
  logic                 w_pair;
  logic [9:0]           w_h_data_nxt;
  logic                 w_h_vld_nxt;
  logic [9:0]           w_out_data_nxt;
  logic                 w_out_vld_nxt;
  logic                 w_add_evt;
  logic                 w_del_evt;

  assign in_rd  = !lrst && (r_state == S_PASS);
  assign w_pop  = in_rd && in_vld;
  // COM must already sit in the hold stage while SKP is popped: a gap breaks the pair
  assign w_pair = r_h_vld && (r_h_data == SKP_SYM1) && w_pop && (in_data == SKP_SYM2);

  always_comb begin
    w_state_nxt    = r_state;
    w_h_data_nxt   = r_h_data;
    w_h_vld_nxt    = r_h_vld;
    w_out_data_nxt = r_h_data;
    w_out_vld_nxt  = r_h_vld;
    w_add_evt      = 1'b0;
    w_del_evt      = 1'b0;
    case (r_state)
      S_PASS: begin
        if (w_pair && r_del_req) begin
          w_out_vld_nxt = 1'b0;
          w_h_vld_nxt   = 1'b0;
          w_del_evt     = 1'b1;
        end else if (w_pair && r_add_req) begin
          w_out_data_nxt = SKP_SYM1;
          w_out_vld_nxt  = 1'b1;
          w_h_data_nxt   = SKP_SYM2;
          w_h_vld_nxt    = 1'b1;
          w_add_evt      = 1'b1;
          w_state_nxt    = S_INS_A;
        end else begin
          w_h_vld_nxt = w_pop;
          if (w_pop) begin
            w_h_data_nxt = in_data;
          end
        end
      end
      S_INS_A: begin
        w_h_data_nxt = SKP_SYM1;
        w_h_vld_nxt  = 1'b1;
        w_state_nxt  = S_INS_B;
      end
      S_INS_B: begin
        w_h_data_nxt = SKP_SYM2;
        w_h_vld_nxt  = 1'b1;
        w_state_nxt  = S_PASS;
      end
      default: begin
        w_state_nxt = S_PASS;
      end
    endcase
  end

  always_ff @(posedge lclk) begin
    if (lrst) begin
      r_state       <= S_PASS;
      r_add_req     <= 1'b0;
      r_del_req     <= 1'b0;
      r_h_data      <= '0;
      r_h_vld       <= 1'b0;
      r_out_data    <= '0;
      r_out_vld     <= 1'b0;
      r_skp_added   <= 1'b0;
      r_skp_deleted <= 1'b0;
      r_add_cnt     <= '0;
      r_del_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_add_req     <= en && (occupancy < c_add_thr);
      r_del_req     <= en && (occupancy > c_del_thr);
      r_h_data      <= w_h_data_nxt;
      r_h_vld       <= w_h_vld_nxt;
      r_out_data    <= w_out_data_nxt;
      r_out_vld     <= w_out_vld_nxt;
      r_skp_added   <= w_add_evt;
      r_skp_deleted <= w_del_evt;
      if (w_add_evt && (r_add_cnt != '1)) begin
        r_add_cnt <= r_add_cnt + 1'b1;
      end
      if (w_del_evt && (r_del_cnt != '1)) begin
        r_del_cnt <= r_del_cnt + 1'b1;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_vld     = r_out_vld;
  assign skp_added   = r_skp_added;
  assign skp_deleted = r_skp_deleted;
  assign add_cnt     = r_add_cnt;
  assign del_cnt     = r_del_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eb_skp_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_eb_skp_ctrl: directed bench for eb_skp_ctrl                        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_eb_skp_ctrl;

  localparam logic [9:0]  COM = 10'h0f9;
  localparam logic [9:0]  SKP = 10'h306;
  localparam logic [9:0]  A   = 10'h0a1;
  localparam logic [9:0]  B   = 10'h0b2;
  localparam logic [10:0] GAP = 11'h400;

  logic       lclk = 1'b0;
  logic       lrst = 1'b1;
  logic       en = 1'b0;
  logic [4:0] occupancy = 5'd0;
  logic [9:0] in_data = 10'd0;
  logic       in_vld = 1'b0;
  logic       in_rd;
  logic [9:0] out_data;
  logic       out_vld;
  logic       skp_added;
  logic       skp_deleted;
  logic [7:0] add_cnt;
  logic [7:0] del_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] src[$];
  logic        tr_rd  [0:1023];
  logic        tr_vld [0:1023];
  logic [9:0]  tr_data[0:1023];
  logic        tr_add [0:1023];
  logic        tr_del [0:1023];

  eb_skp_ctrl dut (
    .lclk        (lclk),
    .lrst        (lrst),
    .en          (en),
    .occupancy   (occupancy),
    .in_data     (in_data),
    .in_vld      (in_vld),
    .in_rd       (in_rd),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .skp_added   (skp_added),
    .skp_deleted (skp_deleted),
    .add_cnt     (add_cnt),
    .del_cnt     (del_cnt)
  );

  always #5 lclk = ~lclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge lclk);
    #1;
  endtask

  task automatic do_reset;
    lrst = 1'b1;
    in_vld = 1'b0;
    src.delete();
    tick;
    tick;
    lrst = 1'b0;
    tick;
    tick;
  endtask

  // Trace index k holds outputs after the edge that ends cycle k
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      if (src.size() > 0 && !src[0][10]) begin
        in_vld  = 1'b1;
        in_data = src[0][9:0];
      end else begin
        in_vld = 1'b0;
      end
      tr_rd[k] = in_rd;
      tick;
      if (tr_rd[k] && src.size() > 0) src.delete(0);
      tr_vld[k]  = out_vld;
      tr_data[k] = out_data;
      tr_add[k]  = skp_added;
      tr_del[k]  = skp_deleted;
    end
    in_vld = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int k, input logic v, input logic [9:0] d);
    chk($sformatf("%s_vld[%0d]", tag, k), {31'd0, tr_vld[k]}, {31'd0, v});
    if (v) chk($sformatf("%s_data[%0d]", tag, k), {22'd0, tr_data[k]}, {22'd0, d});
  endtask

  function automatic int count(input int n, input int which);
    int s = 0;
    for (int k = 0; k < n; k++) begin
      case (which)
        0: s += int'(tr_rd[k]);
        1: s += int'(tr_vld[k]);
        2: s += int'(tr_add[k]);
        default: s += int'(tr_del[k]);
      endcase
    end
    return s;
  endfunction

  initial begin
    // reset state
    tick;
    tick;
    chk("rst_in_rd", {31'd0, in_rd}, 32'd0);
    chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
    chk("rst_out_data", {22'd0, out_data}, 32'd0);
    chk("rst_flags", {30'd0, skp_added, skp_deleted}, 32'd0);
    chk("rst_cnts", {16'd0, add_cnt, del_cnt}, 32'd0);

    // 1: passthrough
    en = 1'b1; occupancy = 5'd8;
    do_reset;
    src = '{11'h001, 11'h002, {1'b0, COM}, {1'b0, SKP}, 11'h003};
    run(7);
    chk_out("t1", 0, 1'b0, 10'h000);
    chk_out("t1", 1, 1'b1, 10'h001);
    chk_out("t1", 2, 1'b1, 10'h002);
    chk_out("t1", 3, 1'b1, COM);
    chk_out("t1", 4, 1'b1, SKP);
    chk_out("t1", 5, 1'b1, 10'h003);
    chk_out("t1", 6, 1'b0, 10'h000);
    chk("t1_rd_cycles", count(7, 0), 32'd7);
    chk("t1_cnts", {16'd0, add_cnt, del_cnt}, 32'd0);

    // 2: deletion
    occupancy = 5'd12;
    do_reset;
    src = '{{1'b0, A}, {1'b0, COM}, {1'b0, SKP}, {1'b0, B}};
    run(6);
    chk_out("t2", 1, 1'b1, A);
    chk_out("t2", 2, 1'b0, 10'h000);
    chk_out("t2", 3, 1'b0, 10'h000);
    chk_out("t2", 4, 1'b1, B);
    chk_out("t2", 5, 1'b0, 10'h000);
    chk("t2_del_pulse", {31'd0, tr_del[2]}, 32'd1);
    chk("t2_del_pulses", count(6, 3), 32'd1);
    chk("t2_del_cnt", {24'd0, del_cnt}, 32'd1);
    chk("t2_add_cnt", {24'd0, add_cnt}, 32'd0);

    // 3: insertion
    occupancy = 5'd4;
    do_reset;
    src = '{{1'b0, A}, {1'b0, COM}, {1'b0, SKP}, {1'b0, B}};
    run(8);
    chk_out("t3", 1, 1'b1, A);
    chk_out("t3", 2, 1'b1, COM);
    chk_out("t3", 3, 1'b1, SKP);
    chk_out("t3", 4, 1'b1, COM);
    chk_out("t3", 5, 1'b1, SKP);
    chk_out("t3", 6, 1'b1, B);
    chk_out("t3", 7, 1'b0, 10'h000);
    chk("t3_rd_stall", {30'd0, tr_rd[3], tr_rd[4]}, 32'd0);
    chk("t3_rd_cycles", count(8, 0), 32'd6);
    chk("t3_add_pulse", {31'd0, tr_add[2]}, 32'd1);
    chk("t3_add_pulses", count(8, 2), 32'd1);
    chk("t3_add_cnt", {24'd0, add_cnt}, 32'd1);

    // 4: COM and SKP separated by an empty cycle
    occupancy = 5'd12;
    do_reset;
    src = '{{1'b0, COM}, GAP, {1'b0, SKP}};
    run(5);
    chk_out("t4", 1, 1'b1, COM);
    chk_out("t4", 2, 1'b0, 10'h000);
    chk_out("t4", 3, 1'b1, SKP);
    chk("t4_del_pulses", count(5, 3), 32'd0);
    chk("t4_del_cnt", {24'd0, del_cnt}, 32'd0);

    // 5: reset while in INS_A
    occupancy = 5'd4;
    do_reset;
    src = '{{1'b0, A}, {1'b0, COM}, {1'b0, SKP}, {1'b0, B}};
    run(3);
    chk("t5_mid_add_cnt", {24'd0, add_cnt}, 32'd1);
    chk("t5_mid_in_rd", {31'd0, in_rd}, 32'd0);
    src.delete();
    lrst = 1'b1;
    #1;
    chk("t5_rst_in_rd0", {31'd0, in_rd}, 32'd0);
    tick;
    chk("t5_out_vld", {31'd0, out_vld}, 32'd0);
    chk("t5_cnts", {16'd0, add_cnt, del_cnt}, 32'd0);
    chk("t5_flag", {31'd0, skp_added}, 32'd0);
    chk("t5_rst_in_rd1", {31'd0, in_rd}, 32'd0);
    lrst = 1'b0;
    #1;
    chk("t5_state_pass", {31'd0, in_rd}, 32'd1);
    tick;
    tick;
    chk("t5_h_discarded", {31'd0, out_vld}, 32'd0);

    // 6: counter saturation, then disabled compensation
    occupancy = 5'd12;
    do_reset;
    for (int i = 0; i < 300; i++) begin
      src.push_back({1'b0, COM});
      src.push_back({1'b0, SKP});
    end
    run(605);
    chk("t6_del_pulses", count(605, 3), 32'd300);
    chk("t6_del_sat", {24'd0, del_cnt}, 32'd255);
    en = 1'b0; occupancy = 5'd15;
    do_reset;
    src = '{{1'b0, COM}, {1'b0, SKP}, {1'b0, COM}, {1'b0, SKP}};
    run(6);
    chk("t6_en0_del_pulses", count(6, 3), 32'd0);
    chk("t6_en0_del_cnt", {24'd0, del_cnt}, 32'd0);
    chk("t6_en0_valid", count(6, 1), 32'd4);
    chk_out("t6_en0", 2, 1'b1, SKP);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
